alu_arbiter: RTL and testbench

- Shares the single combinational ALU (2-bit OP, 16-bit INPUTA/INPUTB, OUT/ZERO/EQUAL) between two requesters.
- Accepts one operation at a time over a valid/ready request handshake and grants round-robin.
- Registers the ALU operands and result.
- Returns OUT/ZERO/EQUAL to the winning requester over a valid/ready response handshake.
- Sits between the datapath control units and the ALU instance; it is the only driver of the ALU inputs.

---
 rtl/alu_arbiter_pkg.sv | 19 +
 rtl/alu_arbiter_if.sv | 55 +++++
 rtl/alu_arbiter_rr_arb2.sv | 15 +
 rtl/alu_arbiter.sv | 95 +++++++++
 tb/tb_alu_arbiter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: ALU opcodes, arbiter states, data width.
package alu_arbiter_pkg;

  localparam int unsigned ALU_WIDTH = 16;

  typedef enum logic [1:0] {
    kADD = 2'd0,
    kSUB = 2'd1,
    kAND = 2'd2,
    kXOR = 2'd3
  } op_mne;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response handshakes plus the ALU pin bundle seen by the arbiter.
interface alu_arbiter_if
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
);

  logic             REQ0_VALID;
  logic             REQ0_READY;
  op_mne            REQ0_OP;
  logic [WIDTH-1:0] REQ0_A;
  logic [WIDTH-1:0] REQ0_B;

  logic             REQ1_VALID;
  logic             REQ1_READY;
  op_mne            REQ1_OP;
  logic [WIDTH-1:0] REQ1_A;
  logic [WIDTH-1:0] REQ1_B;

  logic             RSP0_VALID;
  logic             RSP1_VALID;
  logic             RSP_READY0;
  logic             RSP_READY1;
  logic [WIDTH-1:0] RSP_OUT;
  logic             RSP_ZERO;
  logic             RSP_EQUAL;

  op_mne            OP;
  logic [WIDTH-1:0] INPUTA;
  logic [WIDTH-1:0] INPUTB;
  logic [WIDTH-1:0] OUT;
  logic             ZERO;
  logic             EQUAL;

  modport slave (
    input  REQ0_VALID, REQ0_OP, REQ0_A, REQ0_B,
    input  REQ1_VALID, REQ1_OP, REQ1_A, REQ1_B,
    input  RSP_READY0, RSP_READY1,
    input  OUT, ZERO, EQUAL,
    output REQ0_READY, REQ1_READY,
    output RSP0_VALID, RSP1_VALID, RSP_OUT, RSP_ZERO, RSP_EQUAL,
    output OP, INPUTA, INPUTB
  );

  modport master (
    output REQ0_VALID, REQ0_OP, REQ0_A, REQ0_B,
    output REQ1_VALID, REQ1_OP, REQ1_A, REQ1_B,
    output RSP_READY0, RSP_READY1,
    output OUT, ZERO, EQUAL,
    input  REQ0_READY, REQ1_READY,
    input  RSP0_VALID, RSP1_VALID, RSP_OUT, RSP_ZERO, RSP_EQUAL,
    input  OP, INPUTA, INPUTB
  );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant; ptr names the last winner, which loses a tie.
module rr_arb2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt    = '0;
    gnt[0] = req0 & (~req1 | ptr);
    gnt[1] = req1 & (~req0 | ~ptr);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: accept, execute one cycle,
// hold the registered result until the owning requester takes it.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input logic          CLK,
  input logic          RESET_N,
  alu_arbiter_if.slave bus
);

  arb_state_t       state;
  logic             ptr;
  logic             owner;
  op_mne            op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] out_q;
  logic             zero_q;
  logic             equal_q;
  logic             rsp0_q;
  logic             rsp1_q;
  logic [1:0]       gnt;
  logic             rsp_take;

  rr_arb2 u_rr_arb2 (
    .req0 (bus.REQ0_VALID),
    .req1 (bus.REQ1_VALID),
    .ptr  (ptr),
    .gnt  (gnt)
  );

  always_comb begin
    bus.REQ0_READY = (state == IDLE) && gnt[0];
    bus.REQ1_READY = (state == IDLE) && gnt[1];
    rsp_take       = owner ? bus.RSP_READY1 : bus.RSP_READY0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      ptr     <= 1'b1;
      owner   <= 1'b0;
      op_q    <= kADD;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      equal_q <= 1'b0;
      rsp0_q  <= 1'b0;
      rsp1_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // gnt is non-zero only when the granted requester is valid, i.e. a handshake
          if (gnt != 2'b00) begin
            owner <= gnt[1];
            ptr   <= gnt[1];
            op_q  <= gnt[1] ? bus.REQ1_OP : bus.REQ0_OP;
            a_q   <= gnt[1] ? bus.REQ1_A  : bus.REQ0_A;
            b_q   <= gnt[1] ? bus.REQ1_B  : bus.REQ0_B;
            state <= EXEC;
          end
        end
        EXEC: begin
          out_q   <= bus.OUT;
          zero_q  <= bus.ZERO;
          equal_q <= bus.EQUAL;
          rsp0_q  <= ~owner;
          rsp1_q  <= owner;
          state   <= RESP;
        end
        RESP: begin
          if (rsp_take) begin
            rsp0_q <= 1'b0;
            rsp1_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.OP         = op_q;
  assign bus.INPUTA     = a_q;
  assign bus.INPUTB     = b_q;
  assign bus.RSP_OUT    = out_q;
  assign bus.RSP_ZERO   = zero_q;
  assign bus.RSP_EQUAL  = equal_q;
  assign bus.RSP0_VALID = rsp0_q;
  assign bus.RSP1_VALID = rsp1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: ALU stub, transaction-level reference model, directed and random traffic.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(16)) bus ();

  alu_arbiter #(.WIDTH(16)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Result of the ALU as {EQUAL, ZERO, OUT}
  function automatic logic [17:0] alu_ref(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] o;
    case (op)
      2'd0:    o = a + b;
      2'd1:    o = a - b;
      2'd2:    o = a & b;
      default: o = a ^ b;
    endcase
    return {(a == b), (o == 16'h0000), o};
  endfunction

  always_comb {bus.EQUAL, bus.ZERO, bus.OUT} = alu_ref(bus.OP, bus.INPUTA, bus.INPUTB);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: at most one operation outstanding; response two cycles after accept
  bit          busy = 1'b0;
  int          age = 0;
  int          last = 1;
  bit          p_owner;
  logic [1:0]  p_op;
  logic [15:0] p_a, p_b;
  int          obs_win[$];

  function automatic int winner(input bit v0, input bit v1, input int lst);
    if (v0 && v1) return 1 - lst;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic cycle(input bit v0, input logic [1:0] op0, input logic [15:0] a0, input logic [15:0] b0,
                       input bit v1, input logic [1:0] op1, input logic [15:0] a1, input logic [15:0] b1,
                       input bit rr0, input bit rr1);
    int w;
    logic [17:0] r;
    @(posedge clk);
    #1;
    bus.REQ0_VALID = v0; bus.REQ0_OP = op_mne'(op0); bus.REQ0_A = a0; bus.REQ0_B = b0;
    bus.REQ1_VALID = v1; bus.REQ1_OP = op_mne'(op1); bus.REQ1_A = a1; bus.REQ1_B = b1;
    bus.RSP_READY0 = rr0; bus.RSP_READY1 = rr1;
    #1;
    if (bus.REQ0_READY && v0) obs_win.push_back(0);
    else if (bus.REQ1_READY && v1) obs_win.push_back(1);
    if (busy) age++;
    if (!busy) begin
      w = winner(v0, v1, last);
      chk("req0_ready", bus.REQ0_READY, w == 0);
      chk("req1_ready", bus.REQ1_READY, w == 1);
      chk("idle_rsp_valid", {bus.RSP1_VALID, bus.RSP0_VALID}, 2'b00);
      if (w >= 0) begin
        busy = 1'b1; age = 0; p_owner = (w == 1); last = w;
        p_op = p_owner ? op1 : op0;
        p_a  = p_owner ? a1 : a0;
        p_b  = p_owner ? b1 : b0;
      end
    end else begin
      chk("busy_ready", {bus.REQ1_READY, bus.REQ0_READY}, 2'b00);
      chk("alu_op", bus.OP, p_op);
      chk("alu_a", bus.INPUTA, p_a);
      chk("alu_b", bus.INPUTB, p_b);
      if (age == 1) begin
        chk("exec_rsp_valid", {bus.RSP1_VALID, bus.RSP0_VALID}, 2'b00);
      end else begin
        r = alu_ref(p_op, p_a, p_b);
        chk("rsp_valid", {bus.RSP1_VALID, bus.RSP0_VALID}, p_owner ? 2'b10 : 2'b01);
        chk("rsp_out", bus.RSP_OUT, r[15:0]);
        chk("rsp_zero", bus.RSP_ZERO, r[16]);
        chk("rsp_equal", bus.RSP_EQUAL, r[17]);
        if (p_owner ? rr1 : rr0) busy = 1'b0;
      end
    end
  endtask

  task automatic idle_cycle();
    cycle(0, 2'd0, 16'h0, 16'h0, 0, 2'd0, 16'h0, 16'h0, 1, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && busy; i++) idle_cycle();
    if (busy) chk("drain_timeout", busy, 1'b0);
  endtask

  task automatic single(input bit req, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    drain();
    if (req) cycle(0, 2'd0, 16'h0, 16'h0, 1, op, a, b, 1, 1);
    else     cycle(1, op, a, b, 0, 2'd0, 16'h0, 16'h0, 1, 1);
    drain();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.REQ0_VALID = 1'b0; bus.REQ1_VALID = 1'b0;
    bus.RSP_READY0 = 1'b0; bus.RSP_READY1 = 1'b0;
    #1;
    chk("rst_ready", {bus.REQ1_READY, bus.REQ0_READY}, 2'b00);
    chk("rst_rsp_valid", {bus.RSP1_VALID, bus.RSP0_VALID}, 2'b00);
    chk("rst_op", bus.OP, kADD);
    chk("rst_inputa", bus.INPUTA, 16'h0000);
    chk("rst_inputb", bus.INPUTB, 16'h0000);
    chk("rst_rsp_out", bus.RSP_OUT, 16'h0000);
    chk("rst_rsp_flags", {bus.RSP_EQUAL, bus.RSP_ZERO}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    busy = 1'b0; age = 0; last = 1;
  endtask

  initial begin
    #200000;
    chk("watchdog", 1'b1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    logic [15:0] ra, rb;
    bus.REQ0_VALID = 1'b0; bus.REQ0_OP = kADD; bus.REQ0_A = '0; bus.REQ0_B = '0;
    bus.REQ1_VALID = 1'b0; bus.REQ1_OP = kADD; bus.REQ1_A = '0; bus.REQ1_B = '0;
    bus.RSP_READY0 = 1'b0; bus.RSP_READY1 = 1'b0;
    do_reset();

    single(0, kADD, 16'h0004, 16'h0004);
    chk("add_out", bus.RSP_OUT, 16'h0008);
    chk("add_flags", {bus.RSP_EQUAL, bus.RSP_ZERO}, 2'b10);
    single(1, kSUB, 16'h0004, 16'h0004);
    chk("sub_out", bus.RSP_OUT, 16'h0000);
    chk("sub_flags", {bus.RSP_EQUAL, bus.RSP_ZERO}, 2'b11);
    single(1, kXOR, 16'h0004, 16'h0003);
    chk("xor_out", bus.RSP_OUT, 16'h0007);
    chk("xor_flags", {bus.RSP_EQUAL, bus.RSP_ZERO}, 2'b00);
    single(0, kAND, 16'h00F0, 16'h0FF0);
    chk("and_out", bus.RSP_OUT, 16'h00F0);
    chk("and_flags", {bus.RSP_EQUAL, bus.RSP_ZERO}, 2'b00);

    // Both requesters continuously valid right after reset
    do_reset();
    obs_win.delete();
    for (int i = 0; i < 30 && obs_win.size() < 4; i++)
      cycle(1, 2'(i), 16'(i * 3 + 1), 16'h0011, 1, 2'(i + 1), 16'h0022, 16'(i), 1, 1);
    if (obs_win.size() < 4) chk("alt_timeout", obs_win.size(), 4);
    else for (int i = 0; i < 4; i++) chk("alt_grant", obs_win[i], i % 2);
    drain();

    // Owner 0 stalls its response while requester 1 waits
    cycle(1, kSUB, 16'h1234, 16'h0234, 0, kADD, 16'h0, 16'h0, 0, 1);
    for (int i = 0; i < 6; i++)
      cycle(0, kADD, 16'h0, 16'h0, 1, kXOR, 16'h00FF, 16'h0F0F, 0, 1);
    chk("hold_out", bus.RSP_OUT, 16'h1000);
    cycle(0, kADD, 16'h0, 16'h0, 1, kXOR, 16'h00FF, 16'h0F0F, 1, 1);
    cycle(0, kADD, 16'h0, 16'h0, 1, kXOR, 16'h00FF, 16'h0F0F, 1, 1);
    chk("hold_rel_ready1", bus.REQ1_READY, 1'b1);
    drain();

    // Reset while EXEC: operation dropped, tie goes to requester 0 again
    cycle(1, kADD, 16'h0100, 16'h0200, 0, kADD, 16'h0, 16'h0, 1, 1);
    do_reset();
    for (int i = 0; i < 3; i++) idle_cycle();
    cycle(1, kAND, 16'hFFFF, 16'h00FF, 1, kXOR, 16'h1111, 16'h2222, 1, 1);
    chk("post_rst_tie", {bus.REQ1_READY, bus.REQ0_READY}, 2'b01);
    drain();

    for (int i = 0; i < 400; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, rb,
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rb, 16'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
